// File: rtl/processing_array_nxn_if.sv
// Operand/result bundle for processing_array_nxn.
// master: operand feeder / result consumer side; slave: the array itself.
interface processing_array_nxn_if #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 8
);
  logic [N*DATA_WIDTH-1:0]   i_a_vector;
  logic [N*DATA_WIDTH-1:0]   i_b_vector;
  logic                      i_data_valid;
  logic [K_WIDTH-1:0]        i_k_len;
  logic                      i_read_enable;
  logic                      i_clear_acc;
  logic [N*N*ACC_WIDTH-1:0]  o_result_matrix;
  logic                      o_computation_done;
  logic                      o_ready_for_data;
  logic                      o_overflow_detected;
  logic [K_WIDTH-1:0]        o_beat_count;

  modport master (
    output i_a_vector, i_b_vector, i_data_valid, i_k_len, i_read_enable, i_clear_acc,
    input  o_result_matrix, o_computation_done, o_ready_for_data,
           o_overflow_detected, o_beat_count
  );

  modport slave (
    input  i_a_vector, i_b_vector, i_data_valid, i_k_len, i_read_enable, i_clear_acc,
    output o_result_matrix, o_computation_done, o_ready_for_data,
           o_overflow_detected, o_beat_count
  );
endinterface

// File: rtl/processing_array_nxn.sv
// N x N signed outer-product MAC array: acc[i][j] += a[i]*b[j] per accepted beat.
// Completes after a run-time beat count, holds results until read, sticky overflow.
// Optional feature macro: PROC_ARRAY_SATURATE_EN (clamp on overflow instead of wrap).
// ACC_WIDTH must be >= 2*DATA_WIDTH.
//
// state   | meaning
// S_IDLE  | empty accumulators, waiting for the first beat
// S_ACCUM | computation in progress, more beats expected
// S_DONE  | result complete and frozen until read or clear
module processing_array_nxn #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    i_reset,
  processing_array_nxn_if.slave   bus
);
  localparam int CELLS = N * N;
  localparam int EXT   = ACC_WIDTH + 1 - 2 * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [CELLS*ACC_WIDTH-1:0]   acc_q, acc_d, acc_upd;
  logic [CELLS-1:0]             cell_ovf;
  logic [K_WIDTH-1:0]           count_q, count_d, count_inc;
  logic [K_WIDTH-1:0]           k_len_q, k_len_d, k_eff;
  logic                         ovf_q, ovf_d;

  // Per-cell next value: full-precision product added in ACC_WIDTH+1 bits
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam int C = gi * N + gj;
      logic signed [DATA_WIDTH-1:0]   a_el, b_el;
      logic signed [2*DATA_WIDTH-1:0] prod;
      logic signed [ACC_WIDTH:0]      sum;

      assign a_el = bus.i_a_vector[gi*DATA_WIDTH +: DATA_WIDTH];
      assign b_el = bus.i_b_vector[gj*DATA_WIDTH +: DATA_WIDTH];
      assign prod = $signed({{DATA_WIDTH{a_el[DATA_WIDTH-1]}}, a_el})
                  * $signed({{DATA_WIDTH{b_el[DATA_WIDTH-1]}}, b_el});
      assign sum  = $signed({acc_q[C*ACC_WIDTH+ACC_WIDTH-1], acc_q[C*ACC_WIDTH +: ACC_WIDTH]})
                  + $signed({{EXT{prod[2*DATA_WIDTH-1]}}, prod});
      // top two bits disagree exactly when the sum left the signed ACC_WIDTH range
      assign cell_ovf[C] = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
`ifdef PROC_ARRAY_SATURATE_EN
      assign acc_upd[C*ACC_WIDTH +: ACC_WIDTH] =
        !cell_ovf[C]    ? sum[ACC_WIDTH-1:0] :
        sum[ACC_WIDTH]  ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                          {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
      assign acc_upd[C*ACC_WIDTH +: ACC_WIDTH] = sum[ACC_WIDTH-1:0];
`endif
    end
  end

  assign count_inc = count_q + K_WIDTH'(1);
  assign k_eff     = (bus.i_k_len == '0) ? K_WIDTH'(1) : bus.i_k_len;

  // Next-state and datapath update; clear outranks read, read outranks beats
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    k_len_d = k_len_q;
    ovf_d   = ovf_q;
    if (bus.i_clear_acc) begin
      state_d = S_IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_data_valid) begin
            k_len_d = k_eff;
            acc_d   = acc_upd;
            ovf_d   = ovf_q | (|cell_ovf);
            count_d = K_WIDTH'(1);
            state_d = (k_eff == K_WIDTH'(1)) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.i_data_valid) begin
            acc_d   = acc_upd;
            ovf_d   = ovf_q | (|cell_ovf);
            count_d = count_inc;
            if (count_inc == k_len_q) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.i_read_enable) begin
            state_d = S_IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      k_len_q <= K_WIDTH'(1);
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      k_len_q <= k_len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_result_matrix     = acc_q;
  assign bus.o_computation_done  = (state_q == S_DONE);
  assign bus.o_ready_for_data    = (state_q != S_DONE);
  assign bus.o_overflow_detected = ovf_q;
  assign bus.o_beat_count        = count_q;
endmodule

// File: tb/tb_processing_array_nxn.sv
// Bench for processing_array_nxn: a 32-bit and a 16-bit accumulator instance driven in
// lockstep, directed vector table, hand sequences, and randomized traffic vs a model.
module tb_processing_array_nxn;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  processing_array_nxn_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(32), .K_WIDTH(KW)) bus32();
  processing_array_nxn_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(16), .K_WIDTH(KW)) bus16();

  processing_array_nxn #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(32), .K_WIDTH(KW)) dut32 (
    .clk(clk), .i_reset(rst), .bus(bus32));
  processing_array_nxn #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(16), .K_WIDTH(KW)) dut16 (
    .clk(clk), .i_reset(rst), .bus(bus16));

  int checks = 0;
  int failures = 0;

  // reference model: plain arithmetic on integers
  longint m_acc[2][9];
  bit     m_ovf[2];
  int     m_state;   // 0 idle, 1 accumulating, 2 done
  int     m_cnt;
  int     m_k;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pk(input int x0, input int x1, input int x2);
    logic [7:0] b0, b1, b2;
    b0 = x0[7:0];
    b1 = x1[7:0];
    b2 = x2[7:0];
    return {b2, b1, b0};
  endfunction

  function automatic longint el(input logic [23:0] vec, input int i);
    logic signed [7:0] t;
    t = vec[i*8 +: 8];
    return longint'(t);
  endfunction

  function automatic logic signed [63:0] c32(input int c);
    logic signed [31:0] t;
    t = bus32.o_result_matrix[c*32 +: 32];
    return t;
  endfunction

  function automatic logic signed [63:0] c16(input int c);
    logic signed [15:0] t;
    t = bus16.o_result_matrix[c*16 +: 16];
    return t;
  endfunction

  task automatic m_clear();
    for (int x = 0; x < 2; x++) begin
      for (int c = 0; c < 9; c++) m_acc[x][c] = 0;
      m_ovf[x] = 1'b0;
    end
    m_state = 0;
    m_cnt = 0;
  endtask

  task automatic m_accum(input logic [23:0] av, input logic [23:0] bv);
    for (int x = 0; x < 2; x++) begin
      int w;
      longint hi, lo, s;
      w  = (x == 0) ? 32 : 16;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -hi - 1;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          s = m_acc[x][i*3+j] + el(av, i) * el(bv, j);
          if (s > hi || s < lo) begin
            m_ovf[x] = 1'b1;
`ifdef PROC_ARRAY_SATURATE_EN
            s = (s > hi) ? hi : lo;
`else
            s = (s > hi) ? s - (longint'(1) << w) : s + (longint'(1) << w);
`endif
          end
          m_acc[x][i*3+j] = s;
        end
    end
  endtask

  task automatic model_step(input logic [23:0] av, input logic [23:0] bv, input bit v,
                            input int k, input bit rd, input bit clr, input bit rs);
    if (rs || clr) m_clear();
    else begin
      case (m_state)
        0: if (v) begin
          m_k = (k == 0) ? 1 : k;
          m_accum(av, bv);
          m_cnt = 1;
          m_state = (m_k == 1) ? 2 : 1;
        end
        1: if (v) begin
          m_accum(av, bv);
          m_cnt++;
          if (m_cnt == m_k) m_state = 2;
        end
        default: if (rd) m_clear();
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":done32"},  bus32.o_computation_done,  m_state == 2);
    chk({tag, ":done16"},  bus16.o_computation_done,  m_state == 2);
    chk({tag, ":ready32"}, bus32.o_ready_for_data,    m_state != 2);
    chk({tag, ":ready16"}, bus16.o_ready_for_data,    m_state != 2);
    chk({tag, ":cnt32"},   bus32.o_beat_count,        m_cnt);
    chk({tag, ":cnt16"},   bus16.o_beat_count,        m_cnt);
    chk({tag, ":ovf32"},   bus32.o_overflow_detected, m_ovf[0]);
    chk({tag, ":ovf16"},   bus16.o_overflow_detected, m_ovf[1]);
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("%s:cell32[%0d]", tag, c), c32(c), m_acc[0][c]);
      chk($sformatf("%s:cell16[%0d]", tag, c), c16(c), m_acc[1][c]);
    end
  endtask

  // drive one cycle on both instances, advance the model, check all outputs
  task automatic apply(input string tag, input logic [23:0] av, input logic [23:0] bv, input bit v,
                       input logic [7:0] k, input bit rd, input bit clr, input bit rs);
    bus32.i_a_vector = av;  bus16.i_a_vector = av;
    bus32.i_b_vector = bv;  bus16.i_b_vector = bv;
    bus32.i_data_valid = v; bus16.i_data_valid = v;
    bus32.i_k_len = k;      bus16.i_k_len = k;
    bus32.i_read_enable = rd; bus16.i_read_enable = rd;
    bus32.i_clear_acc = clr;  bus16.i_clear_acc = clr;
    rst = rs;
    @(posedge clk);
    model_step(av, bv, v, int'(k), rd, clr, rs);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic [23:0] a, b;
    bit          v;
    logic [7:0]  k;
    bit          rd, clr;
    bit          e_done;
    logic [7:0]  e_cnt;
    int          e_c00, e_c12, e_c22;
    int          e16_c00;
    bit          e_ovf16;
  } vec_t;

  function automatic vec_t mk(input logic [23:0] a, input logic [23:0] b, input bit v, input int k,
                              input bit rd, input bit clr, input bit d, input int cnt,
                              input int c00, input int c12, input int c22, input int c16, input bit o16);
    vec_t r;
    r.a = a; r.b = b; r.v = v; r.k = k[7:0]; r.rd = rd; r.clr = clr;
    r.e_done = d; r.e_cnt = cnt[7:0]; r.e_c00 = c00; r.e_c12 = c12; r.e_c22 = c22;
    r.e16_c00 = c16; r.e_ovf16 = o16;
    return r;
  endfunction

  vec_t tbl[21];

  initial begin
    logic [23:0] p123, p456, p111, pa, pb, p127, pm;
    int sat16_final, sat16_back;
    p123 = pk(1, 2, 3);
    p456 = pk(4, 5, 6);
    p111 = pk(1, 1, 1);
    pa   = pk(-128, -1, 0);
    pb   = pk(-128, 127, 5);
    p127 = pk(127, 0, 0);
    pm   = pk(-128, 0, 0);
`ifdef PROC_ARRAY_SATURATE_EN
    sat16_final = 32767;
    sat16_back  = 16511;
`else
    sat16_final = -17149;
    sat16_back  = 32131;
`endif
    //            a     b     v k  rd clr done cnt c00    c12 c22 c16          ovf16
    tbl[0]  = mk(p123, p456, 1, 1, 0, 0, 1, 1, 4,     12, 18, 4,           0);
    tbl[1]  = mk(0,    0,    0, 0, 1, 0, 0, 0, 0,     0,  0,  0,           0);
    tbl[2]  = mk(p111, p111, 1, 4, 0, 0, 0, 1, 1,     1,  1,  1,           0);
    tbl[3]  = mk(p111, p111, 0, 4, 0, 0, 0, 1, 1,     1,  1,  1,           0);
    tbl[4]  = mk(p111, p111, 1, 9, 0, 0, 0, 2, 2,     2,  2,  2,           0);
    tbl[5]  = mk(p111, p111, 0, 9, 0, 0, 0, 2, 2,     2,  2,  2,           0);
    tbl[6]  = mk(p111, p111, 1, 4, 0, 0, 0, 3, 3,     3,  3,  3,           0);
    tbl[7]  = mk(p111, p111, 1, 4, 0, 0, 1, 4, 4,     4,  4,  4,           0);
    tbl[8]  = mk(p111, p111, 1, 4, 0, 0, 1, 4, 4,     4,  4,  4,           0);
    tbl[9]  = mk(0,    0,    0, 0, 1, 0, 0, 0, 0,     0,  0,  0,           0);
    tbl[10] = mk(pa,   pb,   1, 1, 0, 0, 1, 1, 16384, -5, 0,  16384,       0);
    tbl[11] = mk(0,    0,    0, 0, 1, 0, 0, 0, 0,     0,  0,  0,           0);
    tbl[12] = mk(p123, p123, 1, 5, 0, 0, 0, 1, 1,     6,  9,  1,           0);
    tbl[13] = mk(p123, p123, 1, 5, 0, 0, 0, 2, 2,     12, 18, 2,           0);
    tbl[14] = mk(p123, p123, 1, 5, 0, 1, 0, 0, 0,     0,  0,  0,           0);
    tbl[15] = mk(p123, p456, 1, 0, 0, 0, 1, 1, 4,     12, 18, 4,           0);
    tbl[16] = mk(0,    0,    0, 0, 1, 0, 0, 0, 0,     0,  0,  0,           0);
    tbl[17] = mk(p127, p127, 1, 3, 0, 0, 0, 1, 16129, 0,  0,  16129,       0);
    tbl[18] = mk(p127, p127, 1, 3, 0, 0, 0, 2, 32258, 0,  0,  32258,       0);
    tbl[19] = mk(p127, p127, 1, 3, 0, 0, 1, 3, 48387, 0,  0,  sat16_final, 1);
    tbl[20] = mk(0,    0,    0, 0, 1, 0, 0, 0, 0,     0,  0,  0,           0);

    m_clear();
    m_k = 1;
    apply("reset0", 0, 0, 0, 0, 0, 0, 1);
    apply("reset1", 0, 0, 1, 3, 0, 0, 1);
    chk("rst:done",  bus32.o_computation_done, 0);
    chk("rst:ready", bus32.o_ready_for_data, 1);
    chk("rst:ovf",   bus32.o_overflow_detected, 0);
    chk("rst:cnt",   bus32.o_beat_count, 0);
    chk("rst:res32", bus32.o_result_matrix == '0, 1);
    chk("rst:res16", bus16.o_result_matrix == '0, 1);
    apply("idle", 0, 0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 21; t++) begin
      string n;
      n = $sformatf("vec%0d", t);
      apply(n, tbl[t].a, tbl[t].b, tbl[t].v, tbl[t].k, tbl[t].rd, tbl[t].clr, 0);
      chk({n, ":done"},   bus32.o_computation_done, tbl[t].e_done);
      chk({n, ":ready"},  bus32.o_ready_for_data, !tbl[t].e_done);
      chk({n, ":cnt"},    bus32.o_beat_count, tbl[t].e_cnt);
      chk({n, ":c00"},    c32(0), tbl[t].e_c00);
      chk({n, ":c12"},    c32(5), tbl[t].e_c12);
      chk({n, ":c22"},    c32(8), tbl[t].e_c22);
      chk({n, ":c16_00"}, c16(0), tbl[t].e16_c00);
      chk({n, ":c16_22"}, c16(8), tbl[t].e_c22);
      chk({n, ":ovf32"},  bus32.o_overflow_detected, 0);
      chk({n, ":ovf16"},  bus16.o_overflow_detected, tbl[t].e_ovf16);
    end

    // signed-operand spot check on the diagonal
    apply("sgn", pa, pb, 1, 1, 0, 0, 0);
    chk("sgn:c11", c32(4), -127);
    chk("sgn:c20", c32(6), 0);
    apply("sgn_rd", 0, 0, 0, 0, 1, 0, 0);

    // reset in the middle of a computation drops the partial result
    apply("mid0", p123, p456, 1, 5, 0, 0, 0);
    apply("mid1", p123, p456, 1, 5, 0, 0, 0);
    apply("mid_rst", p123, p456, 1, 5, 0, 0, 1);
    chk("mid_rst:cnt", bus32.o_beat_count, 0);
    chk("mid_rst:c00", c32(0), 0);
    chk("mid_rst:ready", bus32.o_ready_for_data, 1);

    // overflowed 16-bit cell followed by a negative product
    apply("sat0", p127, p127, 1, 4, 0, 0, 0);
    apply("sat1", p127, p127, 1, 4, 0, 0, 0);
    apply("sat2", p127, p127, 1, 4, 0, 0, 0);
    apply("sat3", pm, p127, 1, 4, 0, 0, 0);
    chk("sat3:c16_00", c16(0), sat16_back);
    chk("sat3:c32_00", c32(0), 32131);
    chk("sat3:ovf16", bus16.o_overflow_detected, 1);
    chk("sat3:done", bus32.o_computation_done, 1);
    apply("sat_rd", 0, 0, 0, 0, 1, 0, 0);

    // randomized traffic against the model
    for (int t = 0; t < 500; t++) begin
      logic [23:0] av, bv;
      bit v, rd, clr, rs;
      av  = 24'($urandom);
      bv  = 24'($urandom);
      v   = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 9) < 2);
      clr = ($urandom_range(0, 39) == 0);
      rs  = ($urandom_range(0, 99) == 0);
      apply($sformatf("rnd%0d", t), av, bv, v, 8'($urandom_range(0, 6)), rd, clr, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/processing_array_nxn.md
# processing_array_nxn

Parametrised successor to the fixed 3x3 processing array: an N x N grid of signed multiply-accumulate cells. Each accepted beat performs the outer-product update acc[i][j] += a[i]*b[j]. A run-time beat count (K) sets when a computation is complete. Results are held until a read handshake releases the array. Accumulator overflow is detected per cell and reported as a sticky flag. The block sits between the operand feeders and the result writeback stage of the CNN accelerator datapath.

## Interface
Parameters:
- N, 3, array dimension; rows and columns, N >= 1.
- DATA_WIDTH, 8, signed operand element width.
- ACC_WIDTH, 32, signed accumulator width; must satisfy ACC_WIDTH >= 2*DATA_WIDTH.
- K_WIDTH, 8, width of the beat-count input and beat counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_a_vector  in  N*DATA_WIDTH  row operands; a[i] = bits [i*DATA_WIDTH +: DATA_WIDTH], two's complement.
- i_b_vector  in  N*DATA_WIDTH  column operands; b[j] packed the same way.
- i_data_valid  in  1  beat strobe; the beat is accepted only when o_ready_for_data=1.
- i_k_len  in  K_WIDTH  beats per computation; sampled on the first accepted beat; 0 is treated as 1.
- i_read_enable  in  1  consumer acknowledge of the result; effective only in DONE.
- i_clear_acc  in  1  synchronous abort/clear, usable in any state.
- o_result_matrix  out  N*N*ACC_WIDTH  acc[i][j] = bits [(i*N+j)*ACC_WIDTH +: ACC_WIDTH].
- o_computation_done  out  1  high in DONE.
- o_ready_for_data  out  1  high in IDLE and ACCUM.
- o_overflow_detected  out  1  sticky OR of all cell overflows in the current computation.
- o_beat_count  out  K_WIDTH  beats accepted in the current computation.

## Operation
- States:
  - IDLE: ready=1, count=0. An accepted beat latches k_len (0 becomes 1), accumulates, and sets count=1. Next state is DONE if k_len=1, else ACCUM.
  - ACCUM: ready=1. An accepted beat accumulates and increments count. When the incremented count equals the latched k_len, next state is DONE. Cycles without i_data_valid leave all state unchanged.
  - DONE: ready=0, done=1; accumulators frozen; i_data_valid is ignored. i_read_enable=1 zeroes all accumulators, count and overflow, and moves to IDLE.
- Arithmetic:
  - Each product is a full signed 2*DATA_WIDTH value, sign-extended to ACC_WIDTH+1, then added to acc.
  - A cell overflows when the sum does not fit in signed ACC_WIDTH.
  - Default behaviour: the result wraps modulo 2^ACC_WIDTH and o_overflow_detected is set. The flag stays set until reset, clear, or read.
- Priority, highest first: i_reset, i_clear_acc, i_read_enable, i_data_valid.
  - i_clear_acc zeroes accumulators, count and overflow, and forces IDLE. A simultaneous beat is dropped.
- i_k_len changes after the first beat have no effect until the next computation.

## Timing
- Reset values: o_result_matrix=0, o_computation_done=0, o_ready_for_data=1, o_overflow_detected=0, o_beat_count=0; state is IDLE.
- Accumulation latency is 1 cycle: the beat accepted at edge t is visible in o_result_matrix after edge t.
- Completion: o_computation_done rises at the same edge that registers the final beat. The result is therefore complete whenever done=1.
- Read: with i_read_enable high in cycle t, after edge t: done=0, ready=1, results=0.
- Back-to-back operation: a new computation can start in the cycle after the read edge (minimum 1 idle cycle between computations).
- Reset or clear mid-ACCUM takes effect at the next edge; no partial result is retained.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- PROC_ARRAY_SATURATE_EN defined: an overflowing cell clamps to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1) according to the direction of overflow. A saturated cell stays clamped until a further addition brings it back in range. o_overflow_detected is still set.
- Not defined: two's-complement wrap as described under Operation.

## Test plan
- k_len=1, a=[1,2,3], b=[4,5,6] -> one cycle later done=1, ready=0, acc[0][0]=4, acc[1][2]=12, acc[2][2]=18, beat_count=1.
- k_len=4, four beats of a=b=[1,1,1] with idle gaps between beats -> done only after the 4th beat, all cells=4; a 5th beat during DONE is ignored (cells stay 4).
- Signed operands: a=[-128,-1,0], b=[-128,127,5] -> acc[0][0]=16384, acc[1][1]=-127, acc[2][*]=0, overflow=0.
- ACC_WIDTH=16, k_len=3, a=b=[127,0,0] -> without the macro, acc[0][0]=-17149 and overflow=1; with PROC_ARRAY_SATURATE_EN, acc[0][0]=32767 and overflow=1.
- k_len=5, i_clear_acc asserted with i_data_valid after 2 beats -> next cycle all cells 0, beat_count=0, IDLE, ready=1; the dropped beat is not counted.
- In DONE, pulse i_read_enable -> next cycle done=0, ready=1, results=0, overflow=0; a new k_len=1 beat completes normally.
